// File: rtl/serial_tx_pkg.sv
// Shared state encodings and line-level constants for the serial transmitter.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Per-bit down-counter: reloads on restart, tick is high while the count sits at zero.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // With CLKS_PER_BIT=1 the reload value is 0, so tick stays high every cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out frame transmitter: start bit, WIDTH data bits, stop bit.
// Handshake: a word transfers on a rising edge where load_valid && load_ready; load_ready is high only in IDLE.
module piso_serial_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter bit LSB_FIRST    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             restart;
    logic             tick;
    logic             accept;
    logic             head_bit;
    logic [WIDTH-1:0] shift_next;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .tick   (tick)
    );

    assign load_ready = (state_q == ST_IDLE);
    assign accept     = load_valid && load_ready;

    // The bit to send next always sits at the outgoing end of the shift register.
    assign head_bit   = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];
    assign shift_next = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        restart   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = LINE_IDLE;
                if (accept) begin
                    state_d   = ST_START;
                    shift_d   = load_data;
                    bit_idx_d = '0;
                    tx_d      = START_BIT;
                    restart   = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = head_bit;
                    shift_d   = shift_next;
                    restart   = 1'b1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    restart = 1'b1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                        tx_d    = STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = head_bit;
                        shift_d   = shift_next;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    tx_d    = LINE_IDLE;
                    done_d  = 1'b1;
                    restart = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = LINE_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= LINE_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx: default instance (8/4/LSB) and a fast MSB-first instance (8/1/MSB).
module tb_piso_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lv_a, lv_b;
    logic [7:0] ld_a, ld_b;
    logic       ready_a, tx_a, busy_a, done_a;
    logic       ready_b, tx_b, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    piso_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(1'b1)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(lv_a),
        .load_ready(ready_a),
        .load_data (ld_a),
        .tx        (tx_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    piso_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(1'b0)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(lv_b),
        .load_ready(ready_b),
        .load_data (ld_b),
        .tx        (tx_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Frame bit n: 0 = start, 1..8 = data, 9 = stop.
    function automatic logic exp_bit(input logic [7:0] word, input int n, input bit lsb);
        if (n == 0) return 1'b0;
        if (n == 9) return 1'b1;
        return lsb ? word[n-1] : word[8-n];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] word, input bit keep_valid);
        ld_a = word;
        lv_a = 1'b1;
        check("a_ready_before_accept", ready_a, 1'b1);
        step();
        if (!keep_valid) lv_a = 1'b0;
    endtask

    // Called #1 after accepting edge E; returns #1 after edge E+40.
    task automatic frame_a(input logic [7:0] word, input bit mutate);
        for (int j = 0; j < 40; j++) begin
            check("a_tx", tx_a, exp_bit(word, j / 4, 1'b1));
            check("a_busy", busy_a, 1'b1);
            check("a_ready_low", ready_a, 1'b0);
            check("a_done_low", done_a, 1'b0);
            if (mutate) begin
                ld_a = (j % 3 == 0) ? 8'hFF : 8'($urandom_range(0, 255));
                lv_a = (j < 36) && (j % 5 < 2);
            end
            step();
        end
        check("a_done_pulse", done_a, 1'b1);
        check("a_busy_end", busy_a, 1'b0);
        check("a_ready_end", ready_a, 1'b1);
        check("a_tx_end", tx_a, 1'b1);
    endtask

    initial begin
        lv_a  = 1'b0;
        lv_b  = 1'b0;
        ld_a  = 8'h00;
        ld_b  = 8'h00;
        rst_n = 1'b1;

        // 1: asynchronous reset with no clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx", tx_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_ready", ready_a, 1'b1);
        check("rst_b_tx", tx_b, 1'b1);
        lv_a = 1'b1;
        ld_a = 8'h5A;
        step();
        step();
        check("rst_ignore_busy", busy_a, 1'b0);
        check("rst_ignore_tx", tx_a, 1'b1);
        lv_a  = 1'b0;
        rst_n = 1'b1;
        step();
        check("post_rst_busy", busy_a, 1'b0);
        check("post_rst_tx", tx_a, 1'b1);

        // 2: single frame 0xA5
        send_a(8'hA5, 1'b0);
        frame_a(8'hA5, 1'b0);
        step();
        check("a5_done_single", done_a, 1'b0);
        check("a5_idle_tx", tx_a, 1'b1);

        // 3: back-to-back with load_valid held high
        send_a(8'h00, 1'b1);
        ld_a = 8'hFF;
        frame_a(8'h00, 1'b0);
        step();
        lv_a = 1'b0;
        frame_a(8'hFF, 1'b0);
        step();
        check("b2b_done_single", done_a, 1'b0);

        // 4: load_valid and load_data activity mid-frame is ignored
        send_a(8'h3C, 1'b0);
        frame_a(8'h3C, 1'b1);
        lv_a = 1'b0;
        step();
        check("ign_no_second_busy", busy_a, 1'b0);
        check("ign_no_second_tx", tx_a, 1'b1);
        step();
        check("ign_still_idle", busy_a, 1'b0);

        // 5: asynchronous reset during data bit 3 of 0x0F
        send_a(8'h0F, 1'b0);
        repeat (17) step();
        check("abort_busy_before", busy_a, 1'b1);
        check("abort_bit3", tx_a, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_tx", tx_a, 1'b1);
        check("abort_busy", busy_a, 1'b0);
        check("abort_done", done_a, 1'b0);
        check("abort_ready", ready_a, 1'b1);
        step();
        step();
        check("abort_no_done", done_a, 1'b0);
        rst_n = 1'b1;
        step();
        send_a(8'h55, 1'b0);
        frame_a(8'h55, 1'b0);
        step();

        // 6: CLKS_PER_BIT=1, MSB first, 0x81
        ld_b = 8'h81;
        lv_b = 1'b1;
        check("b_ready_before_accept", ready_b, 1'b1);
        step();
        lv_b = 1'b0;
        for (int j = 0; j < 10; j++) begin
            check("b_tx", tx_b, exp_bit(8'h81, j, 1'b0));
            check("b_busy", busy_b, 1'b1);
            check("b_done_low", done_b, 1'b0);
            step();
        end
        check("b_done_pulse", done_b, 1'b1);
        check("b_busy_end", busy_b, 1'b0);
        check("b_ready_end", ready_b, 1'b1);
        check("b_tx_end", tx_b, 1'b1);
        step();
        check("b_done_single", done_b, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
Parallel-in, serial-out frame transmitter built on the team's edge-triggered storage. It accepts a WIDTH-bit word through a valid/ready handshake, then drives it onto a single serial line as one frame: a start bit (0), WIDTH data bits, and a stop bit (1). Each bit is held for CLKS_PER_BIT clocks. It is the sending end of the serial link; the matching capture/deserializer side is a separate block.

Parameters:
WIDTH, 8, data bits per frame, >=1
CLKS_PER_BIT, 4, clock cycles each serial bit is held, >=1
LSB_FIRST, 1, 1 = data bit 0 is sent first; 0 = data bit WIDTH-1 is sent first

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
load_valid  input  1  load_data is presented for transmission
load_ready  output  1  block can accept a word (high only in IDLE)
load_data  input  WIDTH  word to transmit
tx  output  1  serial line, idles at 1
busy  output  1  a frame is in progress (START, DATA or STOP)
done  output  1  one-cycle pulse marking frame completion

Behaviour:
- Reset (rst_n low, asynchronous, takes effect without a clock edge):
  - state=IDLE, tx=1, busy=0, done=0, load_ready=1.
  - Shift register and both counters clear to 0.
- Every output is registered except load_ready, which decodes directly from state==IDLE.
- Handshake:
  - A transfer occurs on a rising edge where load_valid && load_ready.
  - On that edge load_data is copied into the shift register and the state moves to START.
  - load_valid while busy is ignored. load_data changes after acceptance have no effect.
- States:
  - IDLE: tx=1. Goes to START on a transfer.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx = the current data bit for CLKS_PER_BIT cycles.
    - The shift register moves one position (right if LSB_FIRST, else left) at each bit boundary.
    - After bit WIDTH-1 the state goes to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Timing:
  - Call the accepting edge E. tx changes to the start bit after E.
  - Frame length is exactly (WIDTH+2)*CLKS_PER_BIT cycles.
  - On edge E+(WIDTH+2)*CLKS_PER_BIT: state=IDLE, done=1 for that single cycle, busy=0, load_ready=1.
  - The next word can be accepted on that same edge's following edge, so there is a minimum gap of 1 idle cycle between frames.
- Bit timer:
  - Down-counter of width $clog2(CLKS_PER_BIT)+1, loaded with CLKS_PER_BIT-1 at every bit start.
  - tick fires when the counter reaches 0.
  - CLKS_PER_BIT=1 must work: tick is high every cycle.
- bit_idx width is $clog2(WIDTH)+1. No wrap: it stops at WIDTH-1.
- Reset mid-frame: the frame is aborted, tx=1 at once, no done pulse. After release, behaviour is identical to a cold reset.
- Illegal state encodings recover to IDLE on the next edge.

Decomposition:
- Package serial_tx_pkg holds:
  - state encodings ST_IDLE, ST_START, ST_DATA, ST_STOP (2-bit)
  - constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1
- One sub-module is natural: bit_timer.
  - Parameter CLKS_PER_BIT.
  - Ports clk, rst_n, restart, tick.
  - It owns the per-bit down-counter.
- Top level holds the FSM, shift register and bit_idx.

Test Plan:
1. Reset: hold rst_n=0 with no clock edges -> tx=1, busy=0, done=0, load_ready=1. A load_valid pulse while in reset is not accepted.
2. WIDTH=8, CLKS_PER_BIT=4, LSB_FIRST=1, send 0xA5 accepted at edge E -> tx sequence 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles (40 cycles total). done=1 for one cycle after edge E+40. busy high for cycles E+1..E+40.
3. Back-to-back 0x00 then 0xFF with load_valid held high -> second word accepted on the first edge where load_ready=1. Frames are separated by exactly 1 idle cycle. Line shows 0,00000000,1,(idle 1),0,11111111,1.
4. During 0x3C transmission, pulse load_valid with load_data=0xFF and change load_data mid-frame -> serial output is still 0x3C. No second frame starts and load_ready stays 0 until completion.
5. Drop rst_n asynchronously during data bit 3 of 0x0F -> tx=1 immediately with no edge, busy=0, no done pulse. After release, 0x55 transmits correctly.
6. CLKS_PER_BIT=1, LSB_FIRST=0, send 0x81 -> tx sequence 0,1,0,0,0,0,0,0,1,1, one cycle each. done after edge E+10.
